// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encoding, width decode and parity helpers shared by uart_tx and uart_rx
package uart_pkg;

    // Frame phase encoding, identical in uart_tx and uart_rx
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Character width code 00..11 -> 5..8 data bits
    function automatic logic [3:0] data_width(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

    // Index of the last data bit of a character (width - 1)
    function automatic logic [2:0] last_bit_idx(input logic [1:0] code);
        return 3'd4 + {1'b0, code};
    endfunction

    // XOR of the active data bits, inverted for odd parity
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic [1:0] code,
                                         input logic       odd);
        logic [7:0] mask;
        mask = 8'hFF >> (4'd8 - data_width(code));
        return (^(data & mask)) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - host-side request/config and line/status signals of uart_tx
interface uart_tx_if;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic [1:0] i_num_bit_data;
    logic       i_stop_bit;
    logic       i_parity_en;
    logic       i_parity_type;
    logic       o_tx_serial;
    logic       o_tx_busy;
    logic       o_tx_done;

    modport master (
        output i_tx_start, i_data, i_num_bit_data, i_stop_bit, i_parity_en, i_parity_type,
        input  o_tx_serial, o_tx_busy, o_tx_done
    );

    modport slave (
        input  i_tx_start, i_data, i_num_bit_data, i_stop_bit, i_parity_en, i_parity_type,
        output o_tx_serial, o_tx_busy, o_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter, 5-8 data bits, optional parity, 1 or 2 stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_tick,
    uart_tx_if.slave   bus
);

    localparam int                CNT_W     = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       code_q, code_d;
    logic             stop2_q, stop2_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic             serial_q, serial_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    // The 16th tick of a bit period ends that bit; ticks in IDLE are never counted
    assign bit_end = (state_q != ST_IDLE) && tx_tick && (tick_q == TICK_LAST);

    // State, datapath and registered outputs; reset returns the line to idle immediately
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            code_q    <= '0;
            stop2_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            code_q    <= code_d;
            stop2_q   <= stop2_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state: accept and latch a character in IDLE, then walk the frame one bit period at a time
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        code_d    = code_q;
        stop2_d   = stop2_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        if (state_q != ST_IDLE && tx_tick) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_tx_start) begin
                    state_d   = ST_START;
                    tick_d    = '0;
                    bit_d     = '0;
                    shift_d   = bus.i_data;
                    code_d    = bus.i_num_bit_data;
                    stop2_d   = bus.i_stop_bit;
                    par_en_d  = bus.i_parity_en;
                    par_bit_d = calc_parity(bus.i_data, bus.i_num_bit_data, bus.i_parity_type);
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == last_bit_idx(code_q)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // bit_q counts completed stop bits; the second one is only sent when stop2_q is set
                if (bit_end) begin
                    if (bit_q[0] == stop2_q) state_d = ST_IDLE;
                    else                     bit_d   = 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs follow the next state so the line changes on the same edge as the state
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shift_d[0];
            ST_PARITY: serial_d = par_bit_d;
            default:   serial_d = 1'b1;
        endcase
    end

    assign bus.o_tx_serial = serial_q;
    assign bus.o_tx_busy   = busy_q;
    assign bus.o_tx_done   = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART: serialises one 5–8-bit character per request, with optional even/odd parity and 1 or 2 stop bits. Bit timing comes from the shared 16x-oversampling baud tick, the same tick that drives `uart_rx`. It sits between the host-side data register or FIFO and the TX pin, and is the loopback partner of `uart_rx` in the subsystem bench.

## Interface
- `OVERSAMPLE`, default 16: `tx_tick` pulses per bit period.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `tx_tick` input 1: single-cycle baud-oversample strobe, 16x baud.
- `i_num_bit_data` input 2: data width; 00=5, 01=6, 10=7, 11=8 bits.
- `i_stop_bit` input 1: 0=1 stop bit, 1=2 stop bits.
- `i_parity_en` input 1: 1 appends a parity bit.
- `i_parity_type` input 1: 0=even, 1=odd.
- `i_data` input 8: character to send, LSB first; bits above the configured width are ignored.
- `i_tx_start` input 1: request; sampled only in IDLE.
- `o_tx_serial` output 1: TX line, idle high.
- `o_tx_busy` output 1: frame in progress.
- `o_tx_done` output 1: one-cycle pulse at end of frame.

## Operation
- States (shared encoding with `uart_rx`):
  - IDLE=0: line 1, busy 0.
  - START=1: line 0.
  - DATA=2: line = data bit.
  - PARITY=3: line = parity bit.
  - STOP=4: line 1.
- IDLE: on `i_tx_start`=1, latch `i_data`, width, stop, parity enable and parity type. Clear the tick counter and bit index. Go to START.
- Configuration and data changes after acceptance do not affect the frame in flight.
- Each bit state lasts exactly OVERSAMPLE `tx_tick` pulses. The state advances on the clock edge that samples the 16th tick.
- DATA shifts out bits 0..N-1, where N = 5 + `i_num_bit_data`.
  - Next state is PARITY if parity is enabled, else STOP.
- Parity = XOR of the N active bits, inverted when odd parity is selected.
- STOP lasts 1 or 2 bit periods, then the block returns to IDLE.
- `i_tx_start` outside IDLE is ignored. There is no queueing.

## Timing
- Reset values: `o_tx_serial`=1, `o_tx_busy`=0, `o_tx_done`=0, state IDLE, counters 0.
- Reset asserted mid-frame forces these values on the next edge. No partial stop bit is sent.
- Outputs are registered.
- `o_tx_serial` drops to 0 and `o_tx_busy` rises in the cycle after the start request is sampled.
- `o_tx_done` and `o_tx_busy` deassertion:
  - Both occur on the same edge that the last stop bit ends.
  - That edge is the first IDLE cycle; `o_tx_done` stays high for that cycle only.
- Back-to-back frames: a start request sampled in the `o_tx_done` cycle is accepted. The next start bit begins one cycle later, so there is no idle gap beyond that cycle.
- Frame length in bit periods = 1 + N + parity_en + (1 + `i_stop_bit`). Minimum is 7 (5N1); maximum is 12 (8E2).
- Each bit lasts OVERSAMPLE tick periods, within ±1 clk. This equals one baud period (104167 ns at 9600 baud).
- A tick coinciding with acceptance is not counted. Counting starts with the first tick after entering START.

## Structure
- Shared package `uart_pkg` holds:
  - state localparams (IDLE..STOP, 3 bits);
  - width decode (2-bit code -> N);
  - the parity function, also used by `uart_rx`.
- Single module `uart_tx` contains:
  - the FSM;
  - a 4-bit tick counter (`$clog2(OVERSAMPLE)`);
  - a 3-bit bit index;
  - an 8-bit shift register.
- No sub-module.

## Test plan
- 8N1, data 0xA5:
  - Line sequence must be 0,1,0,1,0,0,1,0,1,1.
  - Each level lasts 16 ticks.
  - `o_tx_done` pulses once.
  - `o_tx_busy` is high for 10 bit periods.
- 8E1, data 0x03: parity bit is 0. The same frame as 8O1 has parity bit 1. Both frames are received by a looped-back `uart_rx` with `o_parity_err`=0.
- 5-bit, 2 stop bits, data 0xFF:
  - Exactly 5 data bits of 1 are sent.
  - The stop phase lasts 32 ticks.
  - Total frame is 8 bit periods.
- Start while busy: pulse `i_tx_start` with 0x55 mid-frame of 0xA5. Only 0xA5 is transmitted, and there is exactly one done pulse.
- Back-to-back: hold `i_tx_start` high with 0x3C then 0xC3. Two frames with one-cycle spacing are produced, and loopback `uart_rx` reports both correctly.
- Reset at the 4th data bit:
  - Line is 1 and busy is 0 on the next edge.
  - No done pulse.
  - A following 0x81 frame is transmitted correctly.
